// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//   Multi-cycle control FSM for the RV64 subset datapath. Accepts an
//   instruction from the fetch port, latches its opcode and steps the
//   datapath through DECODE / EXEC / MEM / WB. Traps on an illegal opcode or
//   on a data-memory access that exceeds MEM_TIMEOUT cycles.
//
//   Parameter : MEM_TIMEOUT  max MEM cycles without mem_ready (2..255)
//   Option    : MULTICYCLE_PERF_CNT_EN adds cycle_count / retired_count
//
//   Ports
//     clk, rst_n           clock (rising edge), async active-low reset
//     run                  1 = execute, 0 = halt at instruction boundary
//     instr_valid/ready    fetch handshake, instruction sampled on both high
//     instruction[31:0]    instruction word
//     mem_ready            data memory completes current access
//     ir_write, pc_write   IR load / PC <= PC+4
//     branch               conditional PC update (gated by ALU zero)
//     reg_write            register-file write enable
//     mem_read, mem_write  data-memory requests
//     mem_to_reg           writeback source (1 = memory)
//     alu_src              ALU operand B (1 = immediate)
//     alu_op[1:0]          00 add, 01 sub, 10 funct decode
//     imm_sel[1:0]         00 I, 01 S, 10 SB, 11 none
//     state[2:0]           current FSM state
//     trap, trap_cause     sticky trap flag, 01 illegal / 10 mem timeout
//
//   state  | meaning
//   IDLE   | halted, waiting for run
//   FETCH  | offering instr_ready, loading IR and PC on instr_valid
//   DECODE | classifying the latched opcode
//   EXEC   | ALU operation / branch resolve
//   MEM    | data-memory access, timeout counter running
//   WB     | register-file writeback
//   TRAP   | sticky error, left only through reset
// ---------------------------------------------------------------------------
module multicycle_controller #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instruction,
   input  logic        mem_ready,
   output logic        ir_write,
   output logic        pc_write,
   output logic        branch,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_to_reg,
   output logic        alu_src,
   output logic [1:0]  alu_op,
   output logic [1:0]  imm_sel,
   output logic [2:0]  state,
   output logic        trap,
   output logic [1:0]  trap_cause
`ifdef MULTICYCLE_PERF_CNT_EN
   ,
   output logic [31:0] cycle_count,
   output logic [31:0] retired_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam logic [7:0] TC_LAST = 8'(MEM_TIMEOUT - 1);

   state_t      cur, nxt;
   logic [6:0]  opcode_q;
   logic [7:0]  tcnt_q;
   logic        trap_q;
   logic [1:0]  cause_q;
   logic        trap_set;
   logic [1:0]  trap_code;
   logic        end_instr;

   // Only the opcode field is used by the controller.
   logic unused_instr_bits;
   assign unused_instr_bits = ^instruction[31:7];

   logic is_ld, is_sd, is_beq, is_r, is_i, legal;
   assign is_ld  = (opcode_q == 7'b0000011);
   assign is_sd  = (opcode_q == 7'b0100011);
   assign is_beq = (opcode_q == 7'b1100011);
   assign is_r   = (opcode_q == 7'b0110011);
   assign is_i   = (opcode_q == 7'b0010011);
   assign legal  = is_ld | is_sd | is_beq | is_r | is_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur      <= S_IDLE;
         opcode_q <= 7'd0;
         tcnt_q   <= 8'd0;
         trap_q   <= 1'b0;
         cause_q  <= 2'b00;
      end else begin
         cur <= nxt;
         if (cur == S_FETCH && instr_valid)
            opcode_q <= instruction[6:0];
         // EXEC always precedes MEM, so clearing here gives a zero count
         // on the first MEM cycle.
         if (cur == S_EXEC)
            tcnt_q <= 8'd0;
         else if (cur == S_MEM && !mem_ready)
            tcnt_q <= tcnt_q + 8'd1;
         if (trap_set) begin
            trap_q  <= 1'b1;
            cause_q <= trap_code;
         end
      end
   end

   always_comb begin
      nxt         = cur;
      trap_set    = 1'b0;
      trap_code   = 2'b00;
      end_instr   = 1'b0;
      instr_ready = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      branch      = 1'b0;
      reg_write   = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src     = 1'b0;
      alu_op      = 2'b00;
      case (cur)
         S_IDLE: if (run) nxt = S_FETCH;
         S_FETCH: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               nxt      = S_DECODE;
            end
         end
         S_DECODE: begin
            if (legal) nxt = S_EXEC;
            else begin
               nxt       = S_TRAP;
               trap_set  = 1'b1;
               trap_code = 2'b01;
            end
         end
         S_EXEC: begin
            if (is_ld || is_sd) begin
               alu_src = 1'b1;
               nxt     = S_MEM;
            end else if (is_beq) begin
               alu_op    = 2'b01;
               branch    = 1'b1;
               end_instr = 1'b1;
            end else begin
               alu_op  = 2'b10;
               alu_src = is_i;
               nxt     = S_WB;
            end
         end
         S_MEM: begin
            mem_read  = is_ld;
            mem_write = is_sd;
            // mem_ready takes priority over an expiring timeout.
            if (mem_ready) begin
               if (is_ld) nxt = S_WB;
               else       end_instr = 1'b1;
            end else if (tcnt_q == TC_LAST) begin
               nxt       = S_TRAP;
               trap_set  = 1'b1;
               trap_code = 2'b10;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = is_ld;
            end_instr  = 1'b1;
         end
         S_TRAP: nxt = S_TRAP;
         default: nxt = S_IDLE;
      endcase
      if (end_instr) nxt = run ? S_FETCH : S_IDLE;
   end

   always_comb begin
      imm_sel = 2'b11;
      if (cur == S_DECODE || cur == S_EXEC || cur == S_MEM || cur == S_WB) begin
         if (is_ld || is_i) imm_sel = 2'b00;
         else if (is_sd)    imm_sel = 2'b01;
         else if (is_beq)   imm_sel = 2'b10;
      end
   end

   assign state      = cur;
   assign trap       = trap_q;
   assign trap_cause = cause_q;

`ifdef MULTICYCLE_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_count   <= 32'd0;
         retired_count <= 32'd0;
      end else begin
         if (cur != S_IDLE && cur != S_TRAP)
            cycle_count <= cycle_count + 32'd1;
         if (end_instr)
            retired_count <= retired_count + 32'd1;
      end
   end
`endif

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM for the 64-bit RV64 subset datapath.
- Accepts a 32-bit instruction from the fetch port, latches its opcode and sequences the datapath through DECODE, EXEC, MEM and WB.
- Drives imm_sel to the immediate generator and drives ALU, register-file, PC and data-memory controls.
- Traps on illegal opcodes and on data-memory timeout.

Parameters:
- MEM_TIMEOUT, 16, max cycles in MEM waiting for mem_ready before trap (range 2..255).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- run  input  1  level; 1 = execute, 0 = halt at next instruction boundary
- instr_valid  input  1  fetch port has an instruction
- instr_ready  output  1  controller accepts an instruction this cycle
- instruction  input  32  instruction word, sampled on instr_valid & instr_ready
- mem_ready  input  1  data memory completes the current access
- ir_write  output  1  load instruction register
- pc_write  output  1  PC <= PC+4
- branch  output  1  conditional PC update; datapath gates it with ALU zero
- reg_write  output  1  register-file write enable
- mem_read  output  1  data-memory read request
- mem_write  output  1  data-memory write request
- mem_to_reg  output  1  writeback source; 1 = memory, 0 = ALU
- alu_src  output  1  ALU operand B source; 1 = immediate, 0 = rs2
- alu_op  output  2  00 add, 01 sub, 10 funct decode
- imm_sel  output  2  00 I, 01 S, 10 SB, 11 none
- state  output  3  current FSM state
- trap  output  1  sticky trap flag
- trap_cause  output  2  01 illegal opcode, 10 memory timeout

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, latched opcode=0, timeout counter=0, trap=0, trap_cause=00.
  - Every control output 0; imm_sel=11.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE -> FETCH when run=1.
- FETCH:
  - instr_ready=1.
  - On instr_valid: ir_write=1 and pc_write=1 (same cycle), opcode=instruction[6:0] latched, -> DECODE.
  - Otherwise stay in FETCH.
- DECODE: classify the latched opcode.
  - 0000011 LD, 0100011 SD, 1100011 BEQ, 0110011 R-ALU, 0010011 I-ALU -> EXEC.
  - Any other opcode -> TRAP with cause 01.
- EXEC, outputs by class:
  - LD/SD: alu_op=00, alu_src=1.
  - BEQ: alu_op=01, alu_src=0, branch=1.
  - R-ALU: alu_op=10, alu_src=0.
  - I-ALU: alu_op=10, alu_src=1.
- EXEC next state:
  - LD/SD -> MEM.
  - R/I-ALU -> WB.
  - BEQ -> end of instruction.
- MEM:
  - mem_read (LD) or mem_write (SD) held high until mem_ready=1.
  - Timeout counter clears on MEM entry and increments each cycle without mem_ready.
  - On mem_ready: LD -> WB; SD -> end of instruction.
  - If the counter reaches MEM_TIMEOUT-1 without mem_ready: -> TRAP with cause 10.
  - mem_ready in the same cycle as timeout: mem_ready wins, no trap.
- WB: reg_write=1, one cycle; mem_to_reg=1 for LD, 0 otherwise. End of instruction.
- End of instruction: -> FETCH if run=1, else -> IDLE. run is ignored mid-instruction.
- imm_sel is driven from the latched opcode during DECODE, EXEC, MEM and WB: LD/I-ALU 00, SD 01, BEQ 10, R-ALU 11. It is 11 in IDLE, FETCH and TRAP.
- TRAP: all control outputs 0; trap=1 and trap_cause held. Only rst_n exits TRAP.
- Latency per instruction, counted from the FETCH accept cycle to the return to FETCH:
  - LD 5 cycles (with mem_ready in its first MEM cycle).
  - SD 4 cycles, same condition.
  - R/I-ALU 4 cycles.
  - BEQ 3 cycles.
- All outputs are functions of registered state plus latched opcode. Exceptions: instr_ready, ir_write and pc_write, which also depend on instr_valid.

Optional Feature:
- Macro: MULTICYCLE_PERF_CNT_EN.
- When defined:
  - Adds output cycle_count[31:0], incremented every cycle state!=IDLE and !=TRAP.
  - Adds output retired_count[31:0], incremented at each end of instruction.
  - Both are reset to 0 by rst_n and wrap at 2^32.
- When undefined: neither port exists; behaviour otherwise identical.

Test Plan:
- ld x3,2(x0), instruction=0x00203183, mem_ready on the first MEM cycle -> states 1,2,3,4,5,1; imm_sel=00; mem_read one cycle; reg_write=1 with mem_to_reg=1 in WB.
- sd x1,11(x0), instruction=0x001035A3, mem_ready after 3 MEM cycles -> mem_write high for 4 cycles; imm_sel=01; no reg_write; returns to FETCH.
- beq x0,x0,0, instruction=0x00000063 -> branch=1 and alu_op=01 in EXEC; imm_sel=10; back in FETCH 3 cycles after accept.
- Illegal instruction=0x0000007F -> TRAP after DECODE; trap=1, trap_cause=01; instr_ready stays 0 until rst_n pulses low.
- ld with mem_ready held 0 and MEM_TIMEOUT=16 -> TRAP after 16 MEM cycles, trap_cause=10. Same stimulus with mem_ready on the 16th MEM cycle -> WB, no trap.
- add x1,x2,x3, instruction=0x003100B3, with run dropped during EXEC -> WB completes with reg_write=1, then IDLE. With the macro defined, retired_count=1.
